// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I/E decode stage. Register file with optional write-through
// bypass, load-use hazard detection, branch/jump resolution against the fetch
// prediction, and an ID/EX output register with valid/stall/flush control.
module id_stage_pipe #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter int WR_BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_prediction,
  input  logic            i_stall,
  input  logic            i_wr,
  input  logic [4:0]      i_wr_addr,
  input  logic [XLEN-1:0] i_write_data,
  input  logic            i_ex_load,
  input  logic [4:0]      i_ex_rd,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  output logic [XLEN-1:0] o_imm_data,
  output logic [6:0]      o_opcode,
  output logic [2:0]      o_func3,
  output logic [3:0]      o_alu_ctrl,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_branch_pc,
  output logic            o_flush,
  output logic            o_stall
);

  localparam int AW = $clog2(NUM_REGS);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic [XLEN-1:0] regs [NUM_REGS];

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [4:0]      rs1, rs2;
  logic            rs1_ok, rs2_ok, wr_ok;
  logic [XLEN-1:0] rs1_val, rs2_val, imm;
  logic [XLEN-1:0] imm_i, imm_b, imm_j;
  logic [3:0]      alu_ctrl;
  logic            rs1_used, rs2_used, load_use;
  logic            taken, mispredict;
  logic [XLEN-1:0] target;

  // Register file: x0 and out-of-range addresses (RV32E) are never written.
  assign wr_ok = (NUM_REGS == 32) || !i_wr_addr[4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (i_wr && (i_wr_addr != 5'd0) && wr_ok) begin
      regs[i_wr_addr[AW-1:0]] <= i_write_data;
    end
  end

  // Field extraction, operand reads with write-through bypass, immediate select.
  always_comb begin
    opc    = i_instr[6:0];
    f3     = i_instr[14:12];
    rs1    = i_instr[19:15];
    rs2    = i_instr[24:20];
    rs1_ok = (NUM_REGS == 32) || !rs1[4];
    rs2_ok = (NUM_REGS == 32) || !rs2[4];

    rs1_val = '0;
    if ((rs1 != 5'd0) && rs1_ok) begin
      if ((WR_BYPASS != 0) && i_wr && (i_wr_addr == rs1)) rs1_val = i_write_data;
      else                                               rs1_val = regs[rs1[AW-1:0]];
    end
    rs2_val = '0;
    if ((rs2 != 5'd0) && rs2_ok) begin
      if ((WR_BYPASS != 0) && i_wr && (i_wr_addr == rs2)) rs2_val = i_write_data;
      else                                               rs2_val = regs[rs2[AW-1:0]];
    end

    imm_i = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
    imm_b = {{(XLEN-12){i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    imm_j = {{(XLEN-20){i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    imm = '0;
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm = imm_i;
      OPC_STORE:  imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OPC_BRANCH: imm = imm_b;
      OPC_LUI, OPC_AUIPC: imm = {{(XLEN-32){i_instr[31]}}, i_instr[31:12], 12'b0};
      OPC_JAL:    imm = imm_j;
      default:    imm = '0;
    endcase

    alu_ctrl = 4'b0000;
    if ((opc == OPC_OP) || (opc == OPC_OP_IMM))
      alu_ctrl = {(f3 == 3'b101) & i_instr[30], f3};
  end

  // Load-use hazard: EX load writes a register this instruction actually reads.
  always_comb begin
    rs1_used = (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LOAD) ||
               (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_JALR);
    rs2_used = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    load_use = i_valid && i_ex_load && (i_ex_rd != 5'd0) &&
               ((rs1_used && (i_ex_rd == rs1)) || (rs2_used && (i_ex_rd == rs2)));
  end

  assign o_stall = i_stall | (load_use & ~o_flush);

  // Branch/jump resolution on the bypassed operands.
  always_comb begin
    taken      = 1'b0;
    mispredict = 1'b0;
    target     = i_pc + imm_b;
    case (opc)
      OPC_BRANCH: begin
        case (f3)
          3'b000:  taken = (rs1_val == rs2_val);
          3'b001:  taken = (rs1_val != rs2_val);
          3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
          3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
          3'b110:  taken = (rs1_val <  rs2_val);
          3'b111:  taken = (rs1_val >= rs2_val);
          default: taken = 1'b0;
        endcase
        mispredict = (taken != i_prediction);
      end
      OPC_JAL: begin
        taken      = 1'b1;
        target     = i_pc + imm_j;
        mispredict = !i_prediction;
      end
      OPC_JALR: begin
        taken      = 1'b1;
        target     = (rs1_val + imm_i) & {{(XLEN-1){1'b1}}, 1'b0};
        mispredict = 1'b1;
      end
      default: ;
    endcase
  end

  // ID/EX register: stall holds, flush squashes, hazard bubbles, else accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid     <= 1'b0;
      o_pc        <= '0;
      o_rs1_data  <= '0;
      o_rs2_data  <= '0;
      o_imm_data  <= '0;
      o_opcode    <= '0;
      o_func3     <= '0;
      o_alu_ctrl  <= '0;
      o_rd        <= '0;
      o_branch_pc <= '0;
      o_flush     <= 1'b0;
    end else if (i_stall) begin
      o_flush <= 1'b0;
    end else if (o_flush || load_use || !i_valid) begin
      o_valid <= 1'b0;
      o_flush <= 1'b0;
    end else begin
      o_valid    <= 1'b1;
      o_pc       <= i_pc;
      o_rs1_data <= rs1_val;
      o_rs2_data <= rs2_val;
      o_imm_data <= imm;
      o_opcode   <= opc;
      o_func3    <= f3;
      o_alu_ctrl <= alu_ctrl;
      o_rd       <= i_instr[11:7];
      o_flush    <= mispredict;
      if (mispredict) o_branch_pc <= taken ? target : (i_pc + XLEN'(4));
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed scenarios followed by random stimulus, checked
// against a behavioural model of the decode stage.
module tb_id_stage_pipe;

  localparam logic [6:0] OP = 7'h33, OPI = 7'h13, LD = 7'h03, ST = 7'h23, BR = 7'h63;
  localparam logic [6:0] JL = 7'h6F, JR = 7'h67, LU = 7'h37, AU = 7'h17;

  logic clk = 1'b0;
  logic rst_n;
  logic i_valid, i_prediction, i_stall, i_wr, i_ex_load;
  logic [31:0] i_instr, i_pc, i_write_data;
  logic [4:0] i_wr_addr, i_ex_rd;

  logic o_valid, o_flush, o_stall;
  logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_imm_data, o_branch_pc;
  logic [6:0] o_opcode; logic [2:0] o_func3; logic [3:0] o_alu_ctrl; logic [4:0] o_rd;

  logic nb_valid, nb_flush, nb_stall;
  logic [31:0] nb_pc, nb_rs1, nb_rs2, nb_imm, nb_bpc;
  logic [6:0] nb_opc; logic [2:0] nb_f3; logic [3:0] nb_alu; logic [4:0] nb_rd;

  logic ev_valid, ev_flush, ev_stall;
  logic [31:0] ev_pc, ev_rs1, ev_rs2, ev_imm, ev_bpc;
  logic [6:0] ev_opc; logic [2:0] ev_f3; logic [3:0] ev_alu; logic [4:0] ev_rd;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(32), .NUM_REGS(32), .WR_BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc),
    .i_prediction(i_prediction), .i_stall(i_stall), .i_wr(i_wr), .i_wr_addr(i_wr_addr),
    .i_write_data(i_write_data), .i_ex_load(i_ex_load), .i_ex_rd(i_ex_rd),
    .o_valid(o_valid), .o_pc(o_pc), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .o_imm_data(o_imm_data), .o_opcode(o_opcode), .o_func3(o_func3), .o_alu_ctrl(o_alu_ctrl),
    .o_rd(o_rd), .o_branch_pc(o_branch_pc), .o_flush(o_flush), .o_stall(o_stall));

  id_stage_pipe #(.XLEN(32), .NUM_REGS(32), .WR_BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc),
    .i_prediction(i_prediction), .i_stall(i_stall), .i_wr(i_wr), .i_wr_addr(i_wr_addr),
    .i_write_data(i_write_data), .i_ex_load(i_ex_load), .i_ex_rd(i_ex_rd),
    .o_valid(nb_valid), .o_pc(nb_pc), .o_rs1_data(nb_rs1), .o_rs2_data(nb_rs2),
    .o_imm_data(nb_imm), .o_opcode(nb_opc), .o_func3(nb_f3), .o_alu_ctrl(nb_alu),
    .o_rd(nb_rd), .o_branch_pc(nb_bpc), .o_flush(nb_flush), .o_stall(nb_stall));

  id_stage_pipe #(.XLEN(32), .NUM_REGS(16), .WR_BYPASS(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc),
    .i_prediction(i_prediction), .i_stall(i_stall), .i_wr(i_wr), .i_wr_addr(i_wr_addr),
    .i_write_data(i_write_data), .i_ex_load(i_ex_load), .i_ex_rd(i_ex_rd),
    .o_valid(ev_valid), .o_pc(ev_pc), .o_rs1_data(ev_rs1), .o_rs2_data(ev_rs2),
    .o_imm_data(ev_imm), .o_opcode(ev_opc), .o_func3(ev_f3), .o_alu_ctrl(ev_alu),
    .o_rd(ev_rd), .o_branch_pc(ev_bpc), .o_flush(ev_flush), .o_stall(ev_stall));

  int n_checks = 0;
  int n_err = 0;

  // Behavioural model of the 32-register, bypassing stage.
  logic [31:0] m_regs [32];
  logic m_valid, m_flush;
  logic [31:0] m_pc, m_rs1, m_rs2, m_imm, m_bpc, m_opc, m_f3, m_alu, m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 0; m_flush = 0;
    m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_bpc = 0;
    m_opc = 0; m_f3 = 0; m_alu = 0; m_rd = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (i_wr && i_wr_addr == a) return i_write_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] m_immed(input logic [31:0] ins);
    logic [31:0] r;
    case (ins[6:0])
      OPI, LD, JR: r = 32'($signed(ins[31:20]));
      ST:          r = 32'($signed({ins[31:25], ins[11:7]}));
      BR:          r = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      LU, AU:      r = ins & 32'hFFFF_F000;
      JL:          r = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      default:     r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic m_load_use();
    logic [6:0] op;
    logic u1, u2;
    op = i_instr[6:0];
    u1 = (op == OP || op == OPI || op == LD || op == ST || op == BR || op == JR);
    u2 = (op == OP || op == ST || op == BR);
    return i_valid && i_ex_load && i_ex_rd != 0 &&
           ((u1 && i_ex_rd == i_instr[19:15]) || (u2 && i_ex_rd == i_instr[24:20]));
  endfunction

  // One clock: check o_stall before the edge, advance model, check ID/EX after.
  task automatic step();
    logic lu, tk, mis;
    logic [31:0] a, b, imm, tgt;
    lu = m_load_use();
    #1 chk("o_stall", 32'(o_stall), 32'(i_stall | (lu & ~m_flush)));
    a = m_read(i_instr[19:15]);
    b = m_read(i_instr[24:20]);
    imm = m_immed(i_instr);
    if (i_stall) m_flush = 0;
    else if (m_flush) begin m_valid = 0; m_flush = 0; end
    else if (lu || !i_valid) m_valid = 0;
    else begin
      m_valid = 1; m_pc = i_pc; m_rs1 = a; m_rs2 = b; m_imm = imm;
      m_opc = 32'(i_instr[6:0]); m_f3 = 32'(i_instr[14:12]); m_rd = 32'(i_instr[11:7]);
      m_alu = 0;
      if (i_instr[6:0] == OP || i_instr[6:0] == OPI)
        m_alu = m_f3 + ((m_f3 == 5 && i_instr[30]) ? 32'd8 : 32'd0);
      tk = 0; tgt = 0; mis = 0;
      case (i_instr[6:0])
        BR: begin
          case (m_f3)
            0: tk = (a == b);
            1: tk = (a != b);
            4: tk = ($signed(a) < $signed(b));
            5: tk = !($signed(a) < $signed(b));
            6: tk = (a < b);
            7: tk = !(a < b);
            default: tk = 0;
          endcase
          tgt = i_pc + imm; mis = (tk != i_prediction);
        end
        JL: begin tk = 1; tgt = i_pc + imm; mis = !i_prediction; end
        JR: begin tk = 1; tgt = (a + imm) & ~32'd1; mis = 1; end
        default: ;
      endcase
      m_flush = mis;
      if (mis) m_bpc = tk ? tgt : i_pc + 32'd4;
    end
    if (i_wr && i_wr_addr != 0) m_regs[i_wr_addr] = i_write_data;
    @(posedge clk); #1;
    chk("o_valid", 32'(o_valid), 32'(m_valid));
    chk("o_flush", 32'(o_flush), 32'(m_flush));
    chk("o_branch_pc", o_branch_pc, m_bpc);
    if (m_valid) begin
      chk("o_pc", o_pc, m_pc);
      chk("o_rs1_data", o_rs1_data, m_rs1);
      chk("o_rs2_data", o_rs2_data, m_rs2);
      chk("o_imm_data", o_imm_data, m_imm);
      chk("o_opcode", 32'(o_opcode), m_opc);
      chk("o_func3", 32'(o_func3), m_f3);
      chk("o_alu_ctrl", 32'(o_alu_ctrl), m_alu);
      chk("o_rd", 32'(o_rd), m_rd);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic pred, input logic wr, input logic [4:0] wa,
                        input logic [31:0] wd);
    i_valid = v; i_instr = ins; i_pc = pc; i_prediction = pred;
    i_wr = wr; i_wr_addr = wa; i_write_data = wd;
    i_stall = 0; i_ex_load = 0; i_ex_rd = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0] ops [9];
    logic [2:0] bf [6];
    ops = '{OP, OPI, LD, ST, BR, JL, JR, LU, AU};
    bf  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    ins = $urandom;
    ins[6:0]   = ops[$urandom_range(0, 8)];
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    if (ins[6:0] == BR) ins[14:12] = bf[$urandom_range(0, 5)];
    return ins;
  endfunction

  initial begin
    model_reset();
    rst_n = 0;
    set_in(0, 32'd0, 32'd0, 0, 0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_flush", 32'(o_flush), 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_rs1", o_rs1_data, 32'd0);
    chk("rst_bpc", o_branch_pc, 32'd0);
    chk("rst_alu_rd", {o_alu_ctrl, o_rd, o_opcode, o_func3}, 32'd0);
    rst_n = 1;

    // 1: plain add
    set_in(0, 32'd0, 32'd0, 0, 1, 5'd3, 32'd3); step();
    set_in(0, 32'd0, 32'd0, 0, 1, 5'd2, 32'd4); step();
    set_in(1, 32'h00218333, 32'h10, 0, 0, 5'd0, 32'd0); step();
    chk("t1_valid", 32'(o_valid), 32'd1);
    chk("t1_rs1", o_rs1_data, 32'd3);
    chk("t1_rs2", o_rs2_data, 32'd4);
    chk("t1_alu", 32'(o_alu_ctrl), 32'd0);
    chk("t1_rd", 32'(o_rd), 32'd6);
    chk("t1_pc", o_pc, 32'h10);

    // 2: same-cycle write to rs1
    set_in(1, 32'h00218333, 32'h10, 0, 1, 5'd3, 32'h55); step();
    chk("t2_bypass", o_rs1_data, 32'h55);
    chk("t2_nobypass", nb_rs1, 32'd3);

    // 3: bne mispredicted, then correctly predicted
    set_in(0, 32'd0, 32'd0, 0, 1, 5'd6, 32'd5); step();
    set_in(0, 32'd0, 32'd0, 0, 1, 5'd4, 32'd5); step();
    set_in(1, 32'h00431663, 32'h100, 1, 0, 5'd0, 32'd0); step();
    chk("t3_flush", 32'(o_flush), 32'd1);
    chk("t3_bpc", o_branch_pc, 32'h104);
    set_in(0, 32'd0, 32'd0, 0, 0, 5'd0, 32'd0); step();
    chk("t3_pulse", 32'(o_flush), 32'd0);
    set_in(0, 32'd0, 32'd0, 0, 1, 5'd4, 32'd7); step();
    set_in(1, 32'h00431663, 32'h100, 1, 0, 5'd0, 32'd0); step();
    chk("t3_noflush", 32'(o_flush), 32'd0);

    // 4: jal predicted not taken; following instruction squashed
    set_in(1, 32'h00C000EF, 32'h200, 0, 0, 5'd0, 32'd0); step();
    chk("t4_flush", 32'(o_flush), 32'd1);
    chk("t4_bpc", o_branch_pc, 32'h20C);
    set_in(1, 32'h00218333, 32'h204, 0, 0, 5'd0, 32'd0); step();
    chk("t4_squash", 32'(o_valid), 32'd0);

    // 5: load-use stall then release
    set_in(1, 32'h00218333, 32'h300, 0, 0, 5'd0, 32'd0);
    i_ex_load = 1; i_ex_rd = 5'd3;
    #1 chk("t5_stall", 32'(o_stall), 32'd1);
    step();
    chk("t5_bubble", 32'(o_valid), 32'd0);
    i_ex_load = 0; step();
    chk("t5_accept", 32'(o_valid), 32'd1);

    // 6: x0 and RV32E out-of-range registers
    set_in(0, 32'd0, 32'd0, 0, 1, 5'd0, 32'hFF); step();
    set_in(1, 32'h00000333, 32'h400, 0, 0, 5'd0, 32'd0); step();
    chk("t6_x0", o_rs1_data, 32'd0);
    set_in(0, 32'd0, 32'd0, 0, 1, 5'd20, 32'h1234); step();
    set_in(1, 32'h014A0333, 32'h404, 0, 0, 5'd0, 32'd0); step();
    chk("t6_e_rs1", ev_rs1, 32'd0);
    chk("t6_e_rs2", ev_rs2, 32'd0);
    chk("t6_i_rs1", o_rs1_data, 32'h1234);

    // reset during a flush pulse
    set_in(1, 32'h00C000EF, 32'h500, 0, 0, 5'd0, 32'd0); step();
    chk("t6_preflush", 32'(o_flush), 32'd1);
    rst_n = 0;
    #1;
    chk("t6_rst_flush", 32'(o_flush), 32'd0);
    chk("t6_rst_bpc", o_branch_pc, 32'd0);
    chk("t6_rst_valid", 32'(o_valid), 32'd0);
    chk("t6_rst_pc", o_pc, 32'd0);
    model_reset();
    set_in(0, 32'd0, 32'd0, 0, 0, 5'd0, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;

    // random phase
    for (int n = 0; n < 400; n++) begin
      i_valid      = ($urandom_range(0, 3) != 0);
      i_instr      = rand_instr();
      i_pc         = $urandom & 32'hFFFF_FFFC;
      i_prediction = 1'($urandom_range(0, 1));
      i_stall      = ($urandom_range(0, 7) == 0);
      i_wr         = 1'($urandom_range(0, 1));
      i_wr_addr    = 5'($urandom_range(0, 7));
      i_write_data = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3));
      i_ex_load    = ($urandom_range(0, 3) == 0);
      i_ex_rd      = 5'($urandom_range(0, 7));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
